// File: rtl/c5315d_vector_sequencer.sv
// Vector-bank sequencer for the duplicated c5315d datapath: apply, settle, capture, stream.
// Optional MISR signature port and logic when MISR_EN is defined.
module c5315d_vector_sequencer #(
  parameter int VEC_W      = 356,
  parameter int OUT_W      = 246,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH),
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             start,
  input  logic [AW:0]      num_vec,
  output logic [VEC_W-1:0] dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             cap_valid,
  output logic [OUT_W-1:0] cap_data,
  output logic [AW-1:0]    cap_idx,
  output logic             busy,
  output logic             done
`ifdef MISR_EN
  ,
  output logic [OUT_W-1:0] signature
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LD = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;

  state_t           r_state;
  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_idx;
  logic [AW:0]      r_count;
  logic [7:0]       r_settle;
  logic [VEC_W-1:0] r_dut_in;
  logic             r_cap_valid;
  logic [OUT_W-1:0] r_cap_data;
  logic [AW-1:0]    r_cap_idx;
  logic             r_busy;
  logic             r_done;
`ifdef MISR_EN
  logic [OUT_W-1:0] r_sig;
  assign signature = r_sig;
`endif

  logic [AW:0] w_count;
  logic        w_last;

  assign w_count = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
  assign w_last  = (({1'b0, r_idx} + (AW+1)'(1)) == r_count);

  assign dut_in    = r_dut_in;
  assign cap_valid = r_cap_valid;
  assign cap_data  = r_cap_data;
  assign cap_idx   = r_cap_idx;
  assign busy      = r_busy;
  assign done      = r_done;

  // Bank is deliberately unreset so preloaded vectors survive an aborted run.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_count     <= '0;
      r_settle    <= '0;
      r_dut_in    <= '0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_cap_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef MISR_EN
      r_sig       <= '0;
`endif
    end else begin
      r_cap_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_count == '0) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= '0;
              r_count <= w_count;
`ifdef MISR_EN
              r_sig   <= '0;
`endif
              r_state <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          r_dut_in <= r_mem[r_idx];
          r_settle <= SETTLE_LD;
          r_state  <= (SETTLE_CYC > 0) ? S_SETTLE : S_CAPTURE;
        end
        S_SETTLE: begin
          if (r_settle == 8'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_settle <= r_settle - 8'd1;
          end
        end
        S_CAPTURE: begin
          r_cap_data  <= dut_out;
          r_cap_idx   <= r_idx;
          r_cap_valid <= 1'b1;
`ifdef MISR_EN
          r_sig       <= {r_sig[OUT_W-2:0], r_sig[OUT_W-1]} ^ dut_out;
`endif
          r_idx       <= r_idx + AW'(1);
          r_state     <= w_last ? S_DONE : S_APPLY;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c5315d_vector_sequencer.sv
// Directed bench: a settle-1 instance and a settle-0 instance share stimulus; DUT models echo dut_in.
module tb_c5315d_vector_sequencer;
  localparam int VW = 16;
  localparam int OW = 8;
  localparam int D  = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, start;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;
  logic [AW:0]   num_vec;

  logic [VW-1:0] dut_in, dut_in_z;
  logic [OW-1:0] dut_out, dut_out_z, cap_data, cap_data_z;
  logic          cap_valid, cap_valid_z, busy, busy_z, done, done_z;
  logic [AW-1:0] cap_idx, cap_idx_z;
`ifdef MISR_EN
  logic [OW-1:0] sig, sig_z;
`endif

  assign dut_out   = dut_in[OW-1:0];
  assign dut_out_z = dut_in_z[OW-1:0];

  c5315d_vector_sequencer #(.VEC_W(VW), .OUT_W(OW), .DEPTH(D), .AW(AW), .SETTLE_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_vec(num_vec), .dut_in(dut_in), .dut_out(dut_out),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_idx(cap_idx),
    .busy(busy), .done(done)
`ifdef MISR_EN
    , .signature(sig)
`endif
  );

  c5315d_vector_sequencer #(.VEC_W(VW), .OUT_W(OW), .DEPTH(D), .AW(AW), .SETTLE_CYC(0)) u_dut_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_vec(num_vec), .dut_in(dut_in_z), .dut_out(dut_out_z),
    .cap_valid(cap_valid_z), .cap_data(cap_data_z), .cap_idx(cap_idx_z),
    .busy(busy_z), .done(done_z)
`ifdef MISR_EN
    , .signature(sig_z)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  int cap_t[$], cap_i[$], cap_d[$], sig_q[$], capz_t[$];
  int done_t, donez_t, busy_at_done;
  logic [VW-1:0] mem_m [D];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (cap_valid) begin
      cap_t.push_back(cyc);
      cap_i.push_back(int'(cap_idx));
      cap_d.push_back(int'(cap_data));
`ifdef MISR_EN
      sig_q.push_back(int'(sig));
`endif
    end
    if (cap_valid_z) capz_t.push_back(cyc);
    if (done) begin
      done_t       = cyc;
      busy_at_done = int'(busy);
    end
    if (done_z) donez_t = cyc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    cap_t.delete(); cap_i.delete(); cap_d.delete(); sig_q.delete(); capz_t.delete();
    done_t = -1; donez_t = -1; busy_at_done = -1;
  endtask

  task automatic wr(input int a, input logic [VW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    mem_m[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1; num_vec = (AW+1)'(n);
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (busy || busy_z); i++) @(negedge clk);
    check("idle_timeout", {62'd0, busy, busy_z}, 64'd0);
    @(negedge clk);
  endtask

  // Settle-1 instance: capture every 3 cycles, done at count*3+1.
  task automatic check_main(input int n);
    check("ncap", cap_t.size(), n);
    for (int k = 0; k < n && k < cap_t.size(); k++) begin
      check("cap_time", cap_t[k] - t0, 3 * (k + 1));
      check("cap_idx", cap_i[k], k);
      check("cap_data", cap_d[k], int'(mem_m[k][OW-1:0]));
    end
    check("done_time", done_t - t0, n * 3 + 1);
    check("busy_at_done", busy_at_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0; num_vec = '0;
    clear_log();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cap_valid", cap_valid, 0);
    check("rst_cap_data", cap_data, 0);
    check("rst_cap_idx", cap_idx, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_busy_z", busy_z, 0);
    rst = 1'b0;

    for (int i = 0; i < D; i++) wr(i, VW'(i + 1));

    // Basic run, both instances
    clear_log();
    do_start(4);
    wait_idle();
    check_main(4);
    check("hold_dut_in", dut_in, 16'd4);
    check("z_ncap", capz_t.size(), 4);
    check("z_done_time4", donez_t - t0, 9);

    // Zero-settle timing
    clear_log();
    do_start(2);
    wait_idle();
    check("z_ncap2", capz_t.size(), 2);
    if (capz_t.size() == 2) begin
      check("z_cap0_time", capz_t[0] - t0, 2);
      check("z_cap1_time", capz_t[1] - t0, 4);
    end
    check("z_done_time2", donez_t - t0, 5);
    check_main(2);

    // Requests while busy are dropped
    clear_log();
    do_start(4);
    repeat (3) @(negedge clk);
    start = 1'b1; num_vec = 3'd1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'd9;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_idle();
    check_main(4);
    clear_log();
    do_start(1);
    wait_idle();
    check_main(1);

    // Empty run
    clear_log();
    do_start(0);
    wait_idle();
    check_main(0);
    check("z_done_empty", donez_t - t0, 1);

    // Clamp 7 -> 4
    clear_log();
    do_start(7);
    wait_idle();
    check_main(4);

    // Reset during SETTLE
    clear_log();
    do_start(4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_dut_in", dut_in, 0);
    check("abort_cap_valid", cap_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_t, -1);
    check("abort_ncap", cap_t.size(), 0);
    clear_log();
    do_start(1);
    wait_idle();
    check_main(1);
    check("after_abort_dut_in", dut_in, 16'd1);

`ifdef MISR_EN
    wr(0, 16'h00A5);
    wr(1, 16'h0001);
    clear_log();
    do_start(2);
    wait_idle();
    check("misr_n", sig_q.size(), 2);
    if (sig_q.size() == 2) begin
      check("misr_sig0", sig_q[0], 32'hA5);
      check("misr_sig1", sig_q[1], 32'h4A);
    end
    do_start(1);
    check("misr_clear", sig, 8'h00);
    wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
